fx_slave_regs: RTL and testbench
================================

FX_SLAVE_REGS -- requirements
Module: fx_slave_regs

Interface
REQ-001 SHALL have parameter BASE, default 22'h000000, meaning the 22-bit base address of the 16-byte register window (BASE[3:0] = 0).
REQ-002 SHALL have parameter DEV_ID, default 8'hA5, meaning the constant returned at offset 0x0.
REQ-003 clk_sys  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fx_wr  input  1  write strobe, one cycle per write.
REQ-006 fx_waddr  input  22  write address, valid while fx_wr=1.
REQ-007 fx_data  input  8  write data, valid while fx_wr=1.
REQ-008 fx_rd  input  1  read strobe, one cycle per read.
REQ-009 fx_raddr  input  22  read address, valid while fx_rd=1.
REQ-010 fx_q  output  8  read data; ORed with the other slaves on the bus, so it is zero unless this slave holds a valid read.
REQ-011 cfg_reg  output  64  eight R/W control bytes; byte k (bits 8k+7:8k) is offset 0x1+k.
REQ-012 sts_in  input  8  status event bits, each level-sampled every cycle.
REQ-013 evt  input  1  event pulse that is counted.

Function
REQ-014 Address map, offsets from BASE: 0x0 ID (RO), 0x1-0x8 CFG0-7 (RW), 0x9 STS (sticky, W1C), 0xA CNT_L, 0xB CNT_H, 0xC SCRATCH (RW), 0xD-0xF reserved (read 0x00, writes ignored).
REQ-015 A write SHALL be accepted only when fx_wr=1 and fx_waddr[21:4]=BASE[21:4], and it takes effect on the next rising edge.
REQ-016 Read latency SHALL be exactly 1 cycle: on the edge after fx_rd=1 with a hit address, fx_q loads the register value.
REQ-017 On fx_rd=1 with a miss address, fx_q SHALL load 8'h00 on the next edge.
REQ-018 fx_q SHALL hold its value until the next fx_rd.
REQ-019 Simultaneous fx_wr and fx_rd to the same offset SHALL return the pre-write value, because reads sample the register value before the edge.
REQ-020 STS[i] SHALL set when sts_in[i]=1 and clear when a write to 0x9 has data bit i=1.
REQ-021 If an STS set and a clear of the same bit occur in the same cycle, the set SHALL win.
REQ-022 The 16-bit counter SHALL increment by one per cycle with evt=1 and saturate at 16'hFFFF without wrapping.
REQ-023 Any write to 0xA SHALL clear the counter to 0; if the clear coincides with evt=1, the clear wins and the result is 0.
REQ-024 A read of 0xA SHALL return CNT[7:0] and, in the same edge, latch CNT[15:8] into a shadow register.
REQ-025 A read of 0xB SHALL return the shadow register, not the live CNT[15:8], so a 0xA-then-0xB read pair is coherent.
REQ-026 Writes to 0x0, 0xB and 0xD-0xF SHALL have no effect.

Reset
REQ-027 While rst_n=0, asynchronously: fx_q=8'h00, cfg_reg=64'h0, STS=8'h00, CNT=16'h0000, shadow=8'h00, SCRATCH=8'h00.
REQ-028 Reset asserted mid-operation SHALL abort any pending read or write, and no partial update survives.
REQ-029 The first bus access SHALL be honoured on the first clk_sys edge after rst_n deasserts.

Configuration
REQ-030 Macro FX_SLAVE_CNT_EN: when defined, the counter and shadow register exist as specified in REQ-022 to REQ-025.
REQ-031 When FX_SLAVE_CNT_EN is undefined, the counter and shadow register are not built, 0xA and 0xB behave as reserved (read 0x00, writes ignored), and evt is ignored.

Verification
REQ-032 BASE=22'h010000: fx_rd raddr 22'h010000 -> fx_q=8'hA5 one cycle later; fx_rd raddr 22'h020000 -> fx_q=8'h00.
REQ-033 Write 8'h3C to 22'h010003, then read the same address -> cfg_reg[23:16]=8'h3C and fx_q=8'h3C; write to 22'h020003 -> cfg_reg unchanged.
REQ-034 Pulse sts_in=8'h81 for 1 cycle, then read 0x9 -> 8'h81; write 8'h01 -> read 8'h80; hold sts_in[7]=1 while writing 8'h80 -> bit 7 stays 1.
REQ-035 300 evt pulses, read 0xA then 0xB -> 8'h2C then 8'h01; add evt pulses between the two reads -> 0xB still returns 8'h01; write 0xA with evt=1 in the same cycle -> CNT=0.
REQ-036 70000 evt pulses -> CNT saturates at 16'hFFFF; with FX_SLAVE_CNT_EN undefined, reads of 0xA and 0xB return 8'h00.
REQ-037 Assert rst_n=0 mid-sequence after writing CFG, STS and CNT -> all outputs and registers return to their REQ-027 reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fx_slave_regs.sv
// fx_slave_regs: 16-byte register slave on the FX bus.
//
// Register window at BASE (BASE[3:0] must be zero), offsets:
//   0x0 ID (RO, DEV_ID)   0x1-0x8 CFG0-7 (RW)   0x9 STS (sticky, W1C)
//   0xA CNT_L             0xB CNT_H (shadow)    0xC SCRATCH (RW)
//   0xD-0xF reserved (read 0x00, writes ignored)
//
// Build option: define FX_SLAVE_CNT_EN to build the 16-bit saturating event
// counter and its high-byte shadow. Without it, 0xA/0xB read as reserved
// and evt is ignored.
//
// Ports:
//   clk_sys   in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   fx_wr     in   1   write strobe
//   fx_waddr  in  22   write address
//   fx_data   in   8   write data
//   fx_rd     in   1   read strobe
//   fx_raddr  in  22   read address
//   fx_q      out  8   read data, one cycle after fx_rd; zero unless a hit
//   cfg_reg   out 64   CFG bytes, byte k at bits 8k+7:8k = offset 0x1+k
//   sts_in    in   8   status event bits, level-sampled every cycle
//   evt       in   1   event pulse to count
module fx_slave_regs #(
    parameter logic [21:0] BASE   = 22'h000000,
    parameter logic [7:0]  DEV_ID = 8'hA5
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        fx_wr,
    input  logic [21:0] fx_waddr,
    input  logic [7:0]  fx_data,
    input  logic        fx_rd,
    input  logic [21:0] fx_raddr,
    output logic [7:0]  fx_q,
    output logic [63:0] cfg_reg,
    input  logic [7:0]  sts_in,
    input  logic        evt
);

    logic       wr_hit;
    logic       rd_hit;
    logic [3:0] woff;
    logic [3:0] roff;
    logic [3:0] cfg_idx;
    logic [7:0] sts;
    logic [7:0] scratch;
    logic [7:0] sts_clr;
    logic [7:0] rd_val;

    assign wr_hit  = fx_wr && (fx_waddr[21:4] == BASE[21:4]);
    assign rd_hit  = fx_rd && (fx_raddr[21:4] == BASE[21:4]);
    assign woff    = fx_waddr[3:0];
    assign roff    = fx_raddr[3:0];
    assign cfg_idx = woff - 4'd1;
    assign sts_clr = (wr_hit && woff == 4'h9) ? fx_data : '0;

`ifdef FX_SLAVE_CNT_EN
    logic [15:0] cnt;
    logic [7:0]  cnt_shadow;
    logic        cnt_clr;

    assign cnt_clr = wr_hit && (woff == 4'hA);

    // Clear has priority over a coincident event; increment stops at all-ones.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (evt && cnt != '1) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Reading CNT_L snapshots the pre-edge high byte so CNT_L/CNT_H pairs match.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_shadow <= '0;
        end else if (rd_hit && roff == 4'hA) begin
            cnt_shadow <= cnt[15:8];
        end
    end
`else
    logic unused_evt;
    assign unused_evt = evt;
`endif

    always_comb begin
        rd_val = '0;
        case (roff)
            4'h0:    rd_val = DEV_ID;
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8:
                     rd_val = cfg_reg[{roff[2:0] - 3'd1, 3'b000} +: 8];
            4'h9:    rd_val = sts;
`ifdef FX_SLAVE_CNT_EN
            4'hA:    rd_val = cnt[7:0];
            4'hB:    rd_val = cnt_shadow;
`endif
            4'hC:    rd_val = scratch;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg <= '0;
            scratch <= '0;
        end else if (wr_hit) begin
            if (woff >= 4'h1 && woff <= 4'h8) begin
                cfg_reg[{cfg_idx[2:0], 3'b000} +: 8] <= fx_data;
            end
            if (woff == 4'hC) begin
                scratch <= fx_data;
            end
        end
    end

    // New events are ORed in after the clear so a coincident set wins.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sts <= '0;
        end else begin
            sts <= (sts & ~sts_clr) | sts_in;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fx_q <= '0;
        end else if (fx_rd) begin
            fx_q <= rd_hit ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_fx_slave_regs.sv
`timescale 1ns/1ps
module tb_fx_slave_regs;

    localparam logic [21:0] BASE   = 22'h010000;
    localparam logic [7:0]  DEV_ID = 8'hA5;
`ifdef FX_SLAVE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        fx_wr;
    logic [21:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;
    logic [63:0] cfg_reg;
    logic [7:0]  sts_in;
    logic        evt;

    int n_checks = 0;
    int n_fail   = 0;

    fx_slave_regs #(.BASE(BASE), .DEV_ID(DEV_ID)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .fx_wr    (fx_wr),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .fx_q     (fx_q),
        .cfg_reg  (cfg_reg),
        .sts_in   (sts_in),
        .evt      (evt)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] cfg_m [8];
    logic [7:0] sts_m, scratch_m, shadow_m, q_m;
    int         cnt_m;

    function automatic logic [21:0] addr(input logic [3:0] off);
        return {BASE[21:4], off};
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] off);
        logic [15:0] c;
        c = 16'(cnt_m);
        if (off == 4'h0) return DEV_ID;
        if (off >= 4'h1 && off <= 4'h8) return cfg_m[off - 4'h1];
        if (off == 4'h9) return sts_m;
        if (off == 4'hA && CNT_EN) return c[7:0];
        if (off == 4'hB && CNT_EN) return shadow_m;
        if (off == 4'hC) return scratch_m;
        return 8'h00;
    endfunction

    function automatic logic [63:0] model_cfg();
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = cfg_m[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) cfg_m[k] = 8'h00;
        sts_m = 0; scratch_m = 0; shadow_m = 0; q_m = 0; cnt_m = 0;
    endtask

    task automatic model_step(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                              input logic rd, input logic [21:0] ra,
                              input logic [7:0] si, input logic ev);
        logic        rhit, whit;
        logic [7:0]  clr;
        logic [15:0] c;
        bit          cnt_clear;
        rhit = (ra[21:4] == BASE[21:4]);
        whit = wr && (wa[21:4] == BASE[21:4]);
        c = 16'(cnt_m);
        if (rd) begin
            q_m = rhit ? model_read(ra[3:0]) : 8'h00;
            if (rhit && ra[3:0] == 4'hA && CNT_EN) shadow_m = c[15:8];
        end
        clr = 0;
        cnt_clear = 0;
        if (whit) begin
            if (wa[3:0] >= 4'h1 && wa[3:0] <= 4'h8) cfg_m[wa[3:0] - 4'h1] = wd;
            if (wa[3:0] == 4'h9) clr = wd;
            if (wa[3:0] == 4'hA) cnt_clear = 1;
            if (wa[3:0] == 4'hC) scratch_m = wd;
        end
        sts_m = (sts_m & ~clr) | si;
        if (CNT_EN) begin
            if (cnt_clear) cnt_m = 0;
            else if (ev && cnt_m < 65535) cnt_m = cnt_m + 1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %016h expected %016h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                       input logic rd, input logic [21:0] ra,
                       input logic [7:0] si, input logic ev);
        fx_wr = wr; fx_waddr = wa; fx_data = wd;
        fx_rd = rd; fx_raddr = ra; sts_in = si; evt = ev;
        @(posedge clk_sys);
        #1;
        fx_wr = 0; fx_rd = 0; sts_in = 0; evt = 0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] off, input logic [7:0] exp);
        cyc(0, '0, 0, 1, addr(off), 0, 0);
        chk8(name, fx_q, exp);
    endtask

    task automatic evt_pulses(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, '0, 0, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        wr;
        logic [21:0] waddr;
        logic [7:0]  wdata;
        logic        rd;
        logic [21:0] raddr;
        logic [7:0]  sts;
        logic [7:0]  exp_q;
        logic [63:0] exp_cfg;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    initial begin
        rst_n = 0; fx_wr = 0; fx_waddr = 0; fx_data = 0;
        fx_rd = 0; fx_raddr = 0; sts_in = 0; evt = 0;

        //               wr  waddr         wdata  rd  raddr         sts    q      cfg
        vt[0]  = '{1'b0, 22'h0,        8'h00, 1'b1, 22'h010000, 8'h00, 8'hA5, 64'h0};
        vt[1]  = '{1'b0, 22'h0,        8'h00, 1'b1, 22'h020000, 8'h00, 8'h00, 64'h0};
        vt[2]  = '{1'b1, 22'h010003,   8'h3C, 1'b0, 22'h0,      8'h00, 8'h00, 64'h003C_0000};
        vt[3]  = '{1'b0, 22'h0,        8'h00, 1'b1, 22'h010003, 8'h00, 8'h3C, 64'h003C_0000};
        vt[4]  = '{1'b1, 22'h020003,   8'hFF, 1'b0, 22'h0,      8'h00, 8'h3C, 64'h003C_0000};
        vt[5]  = '{1'b0, 22'h0,        8'h00, 1'b0, 22'h0,      8'h81, 8'h3C, 64'h003C_0000};
        vt[6]  = '{1'b0, 22'h0,        8'h00, 1'b1, 22'h010009, 8'h00, 8'h81, 64'h003C_0000};
        vt[7]  = '{1'b1, 22'h010009,   8'h01, 1'b0, 22'h0,      8'h00, 8'h81, 64'h003C_0000};
        vt[8]  = '{1'b0, 22'h0,        8'h00, 1'b1, 22'h010009, 8'h00, 8'h80, 64'h003C_0000};
        vt[9]  = '{1'b1, 22'h010009,   8'h80, 1'b0, 22'h0,      8'h80, 8'h80, 64'h003C_0000};
        vt[10] = '{1'b0, 22'h0,        8'h00, 1'b1, 22'h010009, 8'h00, 8'h80, 64'h003C_0000};
        vt[11] = '{1'b1, 22'h01000C,   8'h5A, 1'b1, 22'h01000C, 8'h00, 8'h00, 64'h003C_0000};
        vt[12] = '{1'b0, 22'h0,        8'h00, 1'b1, 22'h01000C, 8'h00, 8'h5A, 64'h003C_0000};
        vt[13] = '{1'b1, 22'h01000D,   8'h77, 1'b1, 22'h01000D, 8'h00, 8'h00, 64'h003C_0000};
        vt[14] = '{1'b1, 22'h010000,   8'h11, 1'b1, 22'h010000, 8'h00, 8'hA5, 64'h003C_0000};

        // reset state, asynchronously visible before any edge
        #1;
        chk8("reset_q", fx_q, 8'h00);
        chk64("reset_cfg", cfg_reg, 64'h0);
        @(posedge clk_sys); @(posedge clk_sys); #1;
        rst_n = 1;

        for (int i = 0; i < NV; i++) begin
            cyc(vt[i].wr, vt[i].waddr, vt[i].wdata, vt[i].rd, vt[i].raddr, vt[i].sts, 0);
            chk8($sformatf("vec%0d_q", i), fx_q, vt[i].exp_q);
            chk64($sformatf("vec%0d_cfg", i), cfg_reg, vt[i].exp_cfg);
        end

        // counter sequences
        cyc(1, addr(4'hA), 0, 0, '0, 0, 0);
        evt_pulses(300);
        if (CNT_EN) begin
            rd_chk("cnt_lo_300", 4'hA, 8'h2C);
            evt_pulses(7);
            rd_chk("cnt_hi_shadow", 4'hB, 8'h01);
            rd_chk("cnt_lo_307", 4'hA, 8'h33);
            cyc(1, addr(4'hA), 8'h55, 0, '0, 0, 1);
            rd_chk("cnt_clr_wins", 4'hA, 8'h00);
            rd_chk("cnt_hi_after_clr", 4'hB, 8'h00);
            evt_pulses(70000);
            rd_chk("cnt_sat_lo", 4'hA, 8'hFF);
            rd_chk("cnt_sat_hi", 4'hB, 8'hFF);
            evt_pulses(1);
            rd_chk("cnt_sat_hold", 4'hA, 8'hFF);
        end else begin
            rd_chk("cnt_off_lo", 4'hA, 8'h00);
            rd_chk("cnt_off_hi", 4'hB, 8'h00);
        end

        // asynchronous reset mid-sequence
        cyc(1, addr(4'h1), 8'hAB, 0, '0, 8'h0F, 1);
        evt_pulses(3);
        rd_chk("pre_rst_cfg1", 4'h1, 8'hAB);
        #2 rst_n = 0;
        #1;
        chk8("async_rst_q", fx_q, 8'h00);
        chk64("async_rst_cfg", cfg_reg, 64'h0);
        @(posedge clk_sys); #1;
        rst_n = 1;
        rd_chk("first_access_id", 4'h0, DEV_ID);
        rd_chk("rst_sts", 4'h9, 8'h00);
        rd_chk("rst_cnt_lo", 4'hA, 8'h00);
        rd_chk("rst_cnt_hi", 4'hB, 8'h00);
        rd_chk("rst_scratch", 4'hC, 8'h00);

        // randomized run against the reference model
        rst_n = 0; #1; rst_n = 1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        wr, rd, ev;
            logic [21:0] wa, ra;
            logic [7:0]  wd, si;
            logic [31:0] r;
            r  = $urandom;
            wr = r[0] | r[1];
            rd = r[2] | r[3];
            ev = r[4] | r[5];
            r  = $urandom;
            wa = (r[3:0] == 0) ? r[31:10] : {BASE[21:4], r[7:4]};
            ra = (r[11:8] == 0) ? r[31:10] : {BASE[21:4], r[15:12]};
            r  = $urandom;
            wd = r[7:0];
            si = r[15:8] & r[23:16] & r[31:24];
            cyc(wr, wa, wd, rd, ra, si, ev);
            model_step(wr, wa, wd, rd, ra, si, ev);
            chk8("rand_q", fx_q, q_m);
            chk64("rand_cfg", cfg_reg, model_cfg());
        end
        // drain status/counter state through reads
        for (int o = 0; o < 16; o++) begin
            cyc(0, '0, 0, 1, addr(4'(o)), 0, 0);
            model_step(0, '0, 0, 1, addr(4'(o)), 0, 0);
            chk8($sformatf("final_rd_%0h", o), fx_q, q_m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
